// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - fetch-to-decode handshake bundle for the instruction queue
// pipe_in layout: {pc[31:0], instruction[31:0], prediction}.
interface instr_queue_if #(
    parameter int DEPTH = 8
) ();
    localparam int PTR_W = $clog2(DEPTH);

    logic [64:0]    pipe_in;
    logic           fetch_enable;
    logic           flush;
    logic           deq_valid;
    logic           deq_ready;
    logic [31:0]    deq_pc;
    logic [31:0]    deq_instruction;
    logic           deq_prediction;
    logic [PTR_W:0] count;

    modport master (
        output pipe_in,
        output flush,
        output deq_ready,
        input  fetch_enable,
        input  deq_valid,
        input  deq_pc,
        input  deq_instruction,
        input  deq_prediction,
        input  count
    );

    modport slave (
        input  pipe_in,
        input  flush,
        input  deq_ready,
        output fetch_enable,
        output deq_valid,
        output deq_pc,
        output deq_instruction,
        output deq_prediction,
        output count
    );
endinterface

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - in-order first-word-fall-through FIFO between fetch and decode
// Fetch has no valid of its own: every cycle fetch_enable is high and flush is low is a push.
module instr_queue #(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    instr_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        prediction;
    } pipe_in_t;

    pipe_in_t         mem_q [DEPTH];
    pipe_in_t         head_entry;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             fetch_en;
    logic             not_empty;
    logic             push;
    logic             pop;

    // fetch_enable depends only on registered count, so a full queue never
    // grants a push even if decode pops in the same cycle.
    always_comb begin
        fetch_en  = (count_q != FULL_CNT);
        not_empty = (count_q != '0);
        push      = fetch_en & ~q.flush;
        pop       = not_empty & q.deq_ready & ~q.flush;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; consumers qualify data with deq_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= pipe_in_t'(q.pipe_in);
        end
    end

    assign head_entry        = mem_q[head_q];
    assign q.fetch_enable    = fetch_en;
    assign q.deq_valid       = not_empty;
    assign q.deq_pc          = head_entry.pc;
    assign q.deq_instruction = head_entry.instruction;
    assign q.deq_prediction  = head_entry.prediction;
    assign q.count           = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - scoreboard bench for instr_queue
module tb_instr_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_queue_if #(.DEPTH(DEPTH)) bus ();

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    logic [64:0] exp_q [$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // Monitor: per-cycle state checks and in-order comparison on every pop.
    always @(negedge clk) begin
        if (!reset) begin
            check("count", 65'(bus.count), 65'(exp_q.size()));
            check("fetch_enable", 65'(bus.fetch_enable), 65'(exp_q.size() != DEPTH));
            check("deq_valid", 65'(bus.deq_valid), 65'(exp_q.size() != 0));
            if (bus.deq_valid && bus.deq_ready && !bus.flush && exp_q.size() != 0) begin
                check("deq_record", {bus.deq_pc, bus.deq_instruction, bus.deq_prediction}, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic pr,
                        input logic rdy, input logic fl);
        bit will_push;
        bus.pipe_in   = {pc, ins, pr};
        bus.deq_ready = rdy;
        bus.flush     = fl;
        will_push     = !fl && (exp_q.size() != DEPTH);
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (will_push) exp_q.push_back({pc, ins, pr});
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.pipe_in   = '0;
        bus.deq_ready = 1'b0;
        bus.flush     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_count", 65'(bus.count), 65'd0);
        check("reset_deq_valid", 65'(bus.deq_valid), 65'd0);
        check("reset_fetch_enable", 65'(bus.fetch_enable), 65'd1);
        reset = 1'b0;

        // Fill to full; the 9th record must be dropped
        for (int i = 0; i < 9; i++) step(32'(i * 4), 32'h1000 + 32'(i), 1'(i), 1'b0, 1'b0);
        check("full_count", 65'(bus.count), 65'd8);
        check("full_fetch_enable", 65'(bus.fetch_enable), 65'd0);
        check("full_head_pc", 65'(bus.deq_pc), 65'h0);

        // Single pop from full, then one push into the freed slot
        step(32'h24, 32'h2024, 1'b0, 1'b1, 1'b0);
        check("after_pop_count", 65'(bus.count), 65'd7);
        check("after_pop_fetch_enable", 65'(bus.fetch_enable), 65'd1);
        check("after_pop_head_pc", 65'(bus.deq_pc), 65'h4);
        step(32'h28, 32'h2028, 1'b1, 1'b0, 1'b0);
        check("refill_count", 65'(bus.count), 65'd8);
        for (int i = 0; i < 10; i++) step(32'h40 + 32'(i * 4), 32'h3000 + 32'(i), 1'b0, 1'b1, 1'b0);

        // Steady push+pop at count 1 across pointer wrap
        step(32'hBAD0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(32'h1FC, 32'h41FC, 1'b1, 1'b1, 1'b0);
        check("steady_start_count", 65'(bus.count), 65'd1);
        for (int i = 0; i < 20; i++) step(32'h200 + 32'(i * 4), 32'h4200 + 32'(i), 1'(i), 1'b1, 1'b0);
        check("steady_count", 65'(bus.count), 65'd1);
        check("steady_head_pc", 65'(bus.deq_pc), 65'h24C);

        // Flush at count 5 with ready and a live pipe_in
        for (int i = 0; i < 4; i++) step(32'h280 + 32'(i * 4), 32'h5000, 1'b0, 1'b0, 1'b0);
        check("preflush_count", 65'(bus.count), 65'd5);
        step(32'hDEAD0000, 32'hDEAD, 1'b1, 1'b1, 1'b1);
        check("flush_count", 65'(bus.count), 65'd0);
        check("flush_deq_valid", 65'(bus.deq_valid), 65'd0);
        check("flush_fetch_enable", 65'(bus.fetch_enable), 65'd1);
        step(32'h300, 32'h6300, 1'b0, 1'b0, 1'b0);
        check("postflush_valid", 65'(bus.deq_valid), 65'd1);
        check("postflush_pc", 65'(bus.deq_pc), 65'h300);

        // Bit-exact instruction/prediction ordering
        step(32'h400, 32'h0000006F, 1'b1, 1'b0, 1'b0);
        step(32'h404, 32'h00000013, 1'b0, 1'b0, 1'b0);
        step(32'h500, 32'h7500, 1'b0, 1'b1, 1'b0);
        check("jal_instruction", 65'(bus.deq_instruction), 65'h6F);
        check("jal_prediction", 65'(bus.deq_prediction), 65'd1);
        step(32'h504, 32'h7504, 1'b0, 1'b1, 1'b0);
        check("addi_instruction", 65'(bus.deq_instruction), 65'h13);
        check("addi_prediction", 65'(bus.deq_prediction), 65'd0);
        step(32'h508, 32'h7508, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle at count 6
        step(32'hBAD4, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(32'h600 + 32'(i * 4), 32'h8600, 1'b0, 1'b0, 1'b0);
        check("prereset_count", 65'(bus.count), 65'd6);
        #1 reset = 1'b1;
        #1;
        check("async_reset_count", 65'(bus.count), 65'd0);
        check("async_reset_deq_valid", 65'(bus.deq_valid), 65'd0);
        check("async_reset_fetch_enable", 65'(bus.fetch_enable), 65'd1);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        step(32'h700, 32'h9700, 1'b1, 1'b0, 1'b0);
        check("postreset_head_pc", 65'(bus.deq_pc), 65'h700);
        step(32'h704, 32'h9704, 1'b0, 1'b1, 1'b0);
        step(32'h708, 32'h9708, 1'b0, 1'b1, 1'b0);
        step(32'h70C, 32'h970C, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
